main_run_controller: RTL and testbench
======================================

// Module: main_run_controller
// PURPOSE
//  Synthesizable run controller for Bambu-generated kernels: applies kernel reset, pulses start_port,
//  counts cycles to done_port per channel, enforces a timeout and streams per-run result records.
//  Drives NUM_CH kernel instances in lock-step for cfg_runs back-to-back runs. It sits between the
//  board-level host/UART logic and the HLS `main` instances, and replaces simulation-only run control.
// PARAMETERS
//  NUM_CH   1         number of kernel channels started together (1..16)
//  CNT_W    32        cycle-counter width; counters saturate at 2**CNT_W-1
//  RUN_W    16        width of run count / run index
//  TIMEOUT  200000000 cycles in WAIT before remaining channels are declared timed out
// PORTS
//  clock       in   1            system clock
//  reset       in   1            asynchronous, active-low reset
//  cfg_start   in   1            one-cycle pulse; starts a batch (ignored while busy)
//  cfg_runs    in   RUN_W        number of runs, sampled on cfg_start
//  busy        out  1            batch in progress
//  batch_done  out  1            one-cycle pulse when the batch is finished
//  kern_reset  out  1            active-low reset to all kernels
//  start_port  out  1            start pulse to all kernels
//  done_port   in   NUM_CH       kernel done, one bit per channel
//  res_valid   out  1            result record valid
//  res_ready   in   1            consumer accepts record (valid&ready = transfer)
//  res_ch      out  $clog2(NUM_CH)+1  channel index of record
//  res_run     out  RUN_W        run index of record (0-based)
//  res_status  out  2            2'b01 done, 2'b10 timeout
//  res_cycles  out  CNT_W        cycle count (TIMEOUT value if timed out)
// BEHAVIOUR
//  Reset: busy=0 batch_done=0 kern_reset=0 start_port=0 res_valid=0, all counters/indices 0, state IDLE.
//  States: IDLE -> RST0 -> RST1 -> START -> WAIT -> REPORT -> NEXT -> (RST0 | IDLE). Registered outputs.
//  IDLE: kern_reset=0; cfg_start with cfg_runs!=0: latch runs, run_idx=0, busy=1 -> RST0.
//        cfg_start with cfg_runs==0: batch_done pulse next cycle, stay IDLE, no records.
//  RST0, RST1: kern_reset=0 (two full cycles of kernel reset per run).
//  START: kern_reset=1, start_port=1 for exactly this cycle; all counters load 1, done flags clear.
//  WAIT: each channel counter +1 per cycle until its done_port is sampled 1; then the flag latches (sticky)
//        and the counter freezes. done_port high in the START cycle gives cycles=1. Later done_port edges are ignored.
//  Exit WAIT when all flags are set, or when the global wait counter reaches TIMEOUT. Undone channels then
//        get status 2'b10 and cycles=TIMEOUT. A channel finishing in the same cycle as the timeout counts as done.
//  REPORT: one record per channel, ch 0..NUM_CH-1, res_valid held with stable fields until res_ready;
//        back-to-back transfers allowed (one per cycle). kern_reset stays 1 and kernels idle.
//  NEXT: run_idx+1; equals runs -> busy=0, batch_done pulse, IDLE; else RST0.
//  Counter at max value saturates (no wrap). cfg_start while busy is ignored. A reset mid-batch aborts
//        immediately; no partial record is emitted.
// CONFIGURATION
//  RUN_STATS_EN defined: extra outputs stat_min, stat_max (NUM_CH*CNT_W, flattened, ch0 in LSBs).
//    They hold the per-channel min/max of res_cycles over done records of the batch, are cleared on an accepted
//    cfg_start (min=all ones, max=0), and are stable once batch_done is pulsed.
//  Undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package main_run_ctrl_pkg: state enum, status codes (ST_DONE=2'b01, ST_TIMEOUT=2'b10), default widths.
//  Sub-module run_cycle_counter (one per channel): clear/load-1, enable, sticky done flag, saturation.
//  Top module: FSM, global timeout counter, run index, result mux/handshake, optional stats.
// TESTING
//  NUM_CH=1, runs=1, done_port at 10th cycle after start_port -> one record {ch0,run0,01,10}, then batch_done.
//  NUM_CH=2, runs=3, done at 5/7 cycles, res_ready=1 -> 6 records in run/ch order, each run preceded by
//    2-cycle kern_reset low.
//  TIMEOUT=50, ch1 never done -> ch0 status 01 with its own count, ch1 status 10 with cycles=50.
//  res_ready low for 4 cycles during REPORT -> res_valid and fields stable; no record lost or duplicated.
//  cfg_runs=0 -> batch_done pulse only, no start_port. cfg_start during WAIT -> ignored.
//  reset asserted in WAIT -> all outputs reset values at once; RUN_STATS_EN with cycles 8,12,9 -> min 8, max 12.

Source files
------------

// File: rtl/main_run_controller_pkg.sv
// main_run_ctrl_pkg
//   Shared types and constants for the HLS kernel run controller:
//   FSM state encoding, result status codes and default widths.
package main_run_ctrl_pkg;

   localparam int DEF_NUM_CH  = 1;
   localparam int DEF_CNT_W   = 32;
   localparam int DEF_RUN_W   = 16;
   localparam int DEF_TIMEOUT = 200000000;

   localparam logic [1:0] ST_DONE    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST0,
      S_RST1,
      S_START,
      S_WAIT,
      S_REPORT,
      S_NEXT
   } run_state_t;

endpackage

// File: rtl/main_run_controller_if.sv
// main_run_controller_if
//   Result record stream from the run controller to the host side.
//   master : controller (drives res_valid and record fields, samples res_ready)
//   slave  : consumer   (samples record, drives res_ready)
//   Ports  : res_valid, res_ready, res_ch, res_run, res_status, res_cycles
interface main_run_controller_if
   import main_run_ctrl_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int RUN_W  = DEF_RUN_W
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic             res_valid;
   logic             res_ready;
   logic [CH_W-1:0]  res_ch;
   logic [RUN_W-1:0] res_run;
   logic [1:0]       res_status;
   logic [CNT_W-1:0] res_cycles;

   modport master (
      output res_valid, res_ch, res_run, res_status, res_cycles,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_ch, res_run, res_status, res_cycles,
      output res_ready
   );

endinterface

// File: rtl/main_run_controller_counter.sv
// run_cycle_counter
//   Per-channel kernel cycle counter.
//   clock, reset : system clock, async active-low reset
//   load         : START cycle; counter <= 1, flag <= done (done in START means 1 cycle)
//   en           : WAIT cycles; count until done is seen, then freeze
//   done         : kernel done_port bit for this channel
//   cnt, flag    : cycle count and sticky done flag
module run_cycle_counter
   import main_run_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic             done,
   output logic [CNT_W-1:0] cnt,
   output logic             flag
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         flag <= 1'b0;
      end else if (load) begin
         cnt  <= CNT_W'(1);
         flag <= done;
      end else if (en && !flag) begin
         // the cycle in which done is sampled is itself counted
         if (cnt != '1) cnt <= cnt + 1'b1;
         if (done) flag <= 1'b1;
      end
   end

endmodule

// File: rtl/main_run_controller.sv
// main_run_controller
//   Runs NUM_CH HLS kernels in lock-step for cfg_runs back-to-back runs:
//   kernel reset, start pulse, per-channel cycle count, timeout, result records.
//   clock, reset           : system clock, async active-low reset
//   cfg_start, cfg_runs    : batch start pulse and run count
//   busy, batch_done       : batch in progress, end-of-batch pulse
//   kern_reset, start_port : active-low kernel reset, kernel start pulse
//   done_port              : per-channel kernel done
//   res                    : result record stream (master)
//   Optional (RUN_STATS_EN): stat_min / stat_max per-channel min/max of done cycles.
//
//   state    | meaning
//   S_IDLE   | waiting for cfg_start, kernels held in reset
//   S_RST0   | kernel reset, first cycle
//   S_RST1   | kernel reset, second cycle
//   S_START  | start_port pulse, counters load 1
//   S_WAIT   | counting until all done or timeout
//   S_REPORT | one record per channel via valid/ready
//   S_NEXT   | advance run index, loop or finish
module main_run_controller
   import main_run_ctrl_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int RUN_W   = DEF_RUN_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic [RUN_W-1:0]   cfg_runs,
   output logic               busy,
   output logic               batch_done,
   output logic               kern_reset,
   output logic               start_port,
   input  logic [NUM_CH-1:0]  done_port,
   main_run_controller_if.master res
`ifdef RUN_STATS_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] stat_min,
   output logic [NUM_CH*CNT_W-1:0] stat_max
`endif
);

   localparam int               CH_W      = $clog2(NUM_CH) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

   run_state_t       state, state_nxt;
   logic [RUN_W-1:0] runs_q, run_idx;
   logic [CH_W-1:0]  ch_idx;
   logic [CNT_W-1:0] wait_cnt;
   logic             batch_done_q;
   logic [CNT_W-1:0] ch_cnt [NUM_CH];
   logic [NUM_CH-1:0] ch_flag;
   logic [CNT_W-1:0] sel_cnt;
   logic             sel_flag;
   logic             xfer, last_ch, last_run, cnt_load, cnt_en, timeout_hit;

   assign xfer        = res.res_valid && res.res_ready;
   assign last_ch     = (ch_idx == CH_W'(NUM_CH - 1));
   assign last_run    = ((run_idx + 1'b1) == runs_q);
   assign cnt_load    = (state == S_START);
   assign cnt_en      = (state == S_WAIT);
   // wait_cnt trails the channel counters by one, so the final WAIT cycle is cycle TIMEOUT
   assign timeout_hit = (wait_cnt >= TO_LAST);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      run_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
         .clock (clock),
         .reset (reset),
         .load  (cnt_load),
         .en    (cnt_en),
         .done  (done_port[g]),
         .cnt   (ch_cnt[g]),
         .flag  (ch_flag[g])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (cfg_start && (cfg_runs != '0)) state_nxt = S_RST0;
         S_RST0:   state_nxt = S_RST1;
         S_RST1:   state_nxt = S_START;
         S_START:  state_nxt = S_WAIT;
         S_WAIT:   if ((&ch_flag) || timeout_hit) state_nxt = S_REPORT;
         S_REPORT: if (xfer && last_ch) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = last_run ? S_IDLE : S_RST0;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != S_IDLE);
      kern_reset    = (state inside {S_START, S_WAIT, S_REPORT, S_NEXT});
      start_port    = (state == S_START);
      res.res_valid = (state == S_REPORT);
      batch_done    = batch_done_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         runs_q       <= '0;
         run_idx      <= '0;
         ch_idx       <= '0;
         wait_cnt     <= '0;
         batch_done_q <= 1'b0;
      end else begin
         batch_done_q <= 1'b0;
         case (state)
            S_IDLE: if (cfg_start) begin
               runs_q  <= cfg_runs;
               run_idx <= '0;
               if (cfg_runs == '0) batch_done_q <= 1'b1;
            end
            S_START:  wait_cnt <= CNT_W'(1);
            S_WAIT:   if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            S_REPORT: if (xfer) ch_idx <= last_ch ? '0 : ch_idx + 1'b1;
            S_NEXT: begin
               run_idx <= run_idx + 1'b1;
               if (last_run) batch_done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sel_cnt  = '0;
      sel_flag = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == CH_W'(i)) begin
            sel_cnt  = ch_cnt[i];
            sel_flag = ch_flag[i];
         end
      end
   end

   assign res.res_ch     = ch_idx;
   assign res.res_run    = run_idx;
   assign res.res_status = sel_flag ? ST_DONE : ST_TIMEOUT;
   assign res.res_cycles = sel_flag ? sel_cnt : TIMEOUT_C;

`ifdef RUN_STATS_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
      logic [CNT_W-1:0] mn, mx;
      logic             hit;
      assign hit = xfer && sel_flag && (ch_idx == CH_W'(g));
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            mn <= '1;
            mx <= '0;
         end else if ((state == S_IDLE) && cfg_start) begin
            mn <= '1;
            mx <= '0;
         end else if (hit) begin
            if (res.res_cycles < mn) mn <= res.res_cycles;
            if (res.res_cycles > mx) mx <= res.res_cycles;
         end
      end
      assign stat_min[g*CNT_W +: CNT_W] = mn;
      assign stat_max[g*CNT_W +: CNT_W] = mx;
   end
`endif

endmodule

// File: tb/tb_main_run_controller.sv
`timescale 1ns/1ps
module tb_main_run_controller;
   import main_run_ctrl_pkg::*;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 16;
   localparam int RUN_W   = 8;
   localparam int TIMEOUT = 50;
   localparam int CH_W    = $clog2(NUM_CH) + 1;
   localparam int REC_W   = CH_W + RUN_W + 2 + CNT_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_start = 1'b0;
   logic [RUN_W-1:0]  cfg_runs = '0;
   logic              busy, batch_done, kern_reset, start_port;
   logic [NUM_CH-1:0] done_port;
`ifdef RUN_STATS_EN
   logic [NUM_CH*CNT_W-1:0] stat_min, stat_max;
`endif

   main_run_controller_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RUN_W(RUN_W)) rif ();

   main_run_controller #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .cfg_start  (cfg_start),
      .cfg_runs   (cfg_runs),
      .busy       (busy),
      .batch_done (batch_done),
      .kern_reset (kern_reset),
      .start_port (start_port),
      .done_port  (done_port),
      .res        (rif)
`ifdef RUN_STATS_EN
      ,
      .stat_min   (stat_min),
      .stat_max   (stat_max)
`endif
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int k = 0, rr = 0, lows = 0, starts = 0, base = 0;
   int dly0 [4];
   int dly1 [4];
   int low_q [$];
   logic [REC_W-1:0] rec_q [$];

   // kernel model, kern_reset-low counter and record collector
   always @(negedge clock) begin
      if (busy === 1'b1 && kern_reset === 1'b0) lows++;
      if (kern_reset !== 1'b1) k = 0;
      else if (start_port === 1'b1) begin
         k = 1;
         starts++;
         low_q.push_back(lows);
         lows = 0;
      end else if (k > 0 && k < 100000) k++;
      rr = starts - base - 1;
      if (rr < 0) rr = 0;
      if (rr > 3) rr = 3;
      done_port[0] = (k != 0) && (k == dly0[rr]);
      done_port[1] = (k != 0) && (k == dly1[rr]);
      if (rif.res_valid === 1'b1 && rif.res_ready === 1'b1)
         rec_q.push_back({rif.res_ch, rif.res_run, rif.res_status, rif.res_cycles});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] rec(input int ch, input int run, input int st, input int cyc);
      return {CH_W'(ch), RUN_W'(run), 2'(st), CNT_W'(cyc)};
   endfunction

   task automatic chk_rec(input string tag, input logic [REC_W-1:0] exp);
      chk({tag, "_present"}, rec_q.size() > 0, 1);
      if (rec_q.size() > 0) chk(tag, rec_q.pop_front(), exp);
   endtask

   // which: 0 start_port, 1 res_valid, 2 batch_done
   task automatic wait_for(input int which, input string tag, input int budget);
      int   n = 0;
      logic hit = 1'b0;
      while (n < budget) begin
         @(negedge clock);
         n++;
         case (which)
            0:       hit = start_port;
            1:       hit = rif.res_valid;
            default: hit = batch_done;
         endcase
         if (hit === 1'b1) break;
      end
      chk(tag, hit, 1);
   endtask

   task automatic start_batch(input int runs);
      base = starts;
      @(posedge clock);
      #1 cfg_runs = RUN_W'(runs);
      cfg_start = 1'b1;
      @(posedge clock);
      #1 cfg_start = 1'b0;
   endtask

   task automatic set_dly(input int a0, a1, a2, b0, b1, b2);
      dly0[0] = a0; dly0[1] = a1; dly0[2] = a2; dly0[3] = a2;
      dly1[0] = b0; dly1[1] = b1; dly1[2] = b2; dly1[3] = b2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rif.res_ready = 1'b1;
      set_dly(5, 5, 5, 7, 7, 7);
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_batch_done", batch_done, 0);
      chk("rst_kern_reset", kern_reset, 0);
      chk("rst_start_port", start_port, 0);
      chk("rst_res_valid", rif.res_valid, 0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);

      // cfg_runs == 0: batch_done only
      start_batch(0);
      @(negedge clock);
      chk("zero_batch_done", batch_done, 1);
      chk("zero_busy", busy, 0);
      @(negedge clock);
      chk("zero_pulse_end", batch_done, 0);
      repeat (5) @(negedge clock);
      chk("zero_no_start", starts - base, 0);

      // 3 runs, done at 5/7, cfg_start during WAIT ignored
      rec_q.delete();
      low_q.delete();
      start_batch(3);
      wait_for(0, "b3_first_start", 20);
      @(posedge clock);
      #1 cfg_runs = RUN_W'(5);
      cfg_start = 1'b1;
      @(posedge clock);
      #1 cfg_start = 1'b0;
      wait_for(2, "b3_batch_done", 500);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 2; c++)
            chk_rec($sformatf("b3_rec_r%0d_c%0d", r, c), rec(c, r, 1, (c == 0) ? 5 : 7));
      chk("b3_no_extra_rec", rec_q.size(), 0);
      repeat (10) @(negedge clock);
      chk("b3_starts", starts - base, 3);
      chk("b3_idle", busy, 0);
      chk("b3_low_entries", low_q.size(), 3);
      for (int r = 0; r < 3; r++)
         if (r < low_q.size()) chk($sformatf("b3_rst_low_r%0d", r), low_q[r], 2);

      // timeout: ch1 never done
      set_dly(5, 5, 5, 0, 0, 0);
      rec_q.delete();
      start_batch(1);
      wait_for(2, "to_batch_done", 200);
      chk_rec("to_rec_ch0", rec(0, 0, 1, 5));
      chk_rec("to_rec_ch1", rec(1, 0, 2, TIMEOUT));
      chk("to_no_extra_rec", rec_q.size(), 0);

      // res_ready held low during REPORT
      set_dly(3, 3, 3, 4, 4, 4);
      rec_q.delete();
      rif.res_ready = 1'b0;
      start_batch(1);
      wait_for(1, "stall_valid_rise", 50);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("stall_valid_%0d", i), rif.res_valid, 1);
         chk($sformatf("stall_fields_%0d", i),
             {rif.res_ch, rif.res_run, rif.res_status, rif.res_cycles}, rec(0, 0, 1, 3));
      end
      chk("stall_no_xfer", rec_q.size(), 0);
      @(posedge clock);
      #1 rif.res_ready = 1'b1;
      wait_for(2, "stall_batch_done", 50);
      chk_rec("stall_rec_ch0", rec(0, 0, 1, 3));
      chk_rec("stall_rec_ch1", rec(1, 0, 1, 4));
      chk("stall_no_dup", rec_q.size(), 0);

      // reset asserted in WAIT aborts at once
      set_dly(0, 0, 0, 0, 0, 0);
      rec_q.delete();
      start_batch(2);
      wait_for(0, "abort_start", 20);
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_kern_reset", kern_reset, 0);
      chk("abort_start_port", start_port, 0);
      chk("abort_res_valid", rif.res_valid, 0);
      chk("abort_batch_done", batch_done, 0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (80) @(negedge clock);
      chk("abort_no_rec", rec_q.size(), 0);
      chk("abort_no_restart", starts - base, 1);
      chk("abort_idle", busy, 0);

`ifdef RUN_STATS_EN
      set_dly(8, 12, 9, 5, 5, 5);
      rec_q.delete();
      start_batch(3);
      wait_for(2, "stat_batch_done", 500);
      chk("stat_min_ch0", stat_min[CNT_W-1:0], 8);
      chk("stat_max_ch0", stat_max[CNT_W-1:0], 12);
      chk("stat_min_ch1", stat_min[2*CNT_W-1:CNT_W], 5);
      chk("stat_max_ch1", stat_max[2*CNT_W-1:CNT_W], 5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
